store_data_buffer: RTL and testbench
====================================

# store_data_buffer

Parametrised store-data path for the 16-bit CPU's MEM stage. It selects store data from NUM_SRC register-file sources or the forwarding path, and queues address/data pairs in a DEPTH-entry FIFO. It drains the FIFO to the shared RAM port whenever the arbiter grants the bus, so a store never stalls the pipeline unless the buffer is full. Optionally, the youngest matching pending store is forwarded to loads.

## Interface

Parameters:
- DATA_W, 16, data width
- ADDR_W, 16, address width
- NUM_SRC, 4, number of selectable store-data sources (≥2)
- DEPTH, 4, FIFO entries (power of two, ≥2)
- NOP_VALUE, 16'h0101, data queued when src_sel ≥ NUM_SRC and fwd_en low (zero-extended/truncated to DATA_W)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- src_data  in  NUM_SRC*DATA_W  flattened sources, source i at bits [i*DATA_W +: DATA_W]
- src_sel  in  $clog2(NUM_SRC)+1  source index
- fwd_en  in  1  forwarding enable, overrides src_sel
- fwd_data  in  DATA_W  forwarded data
- push_valid  in  1  store request this cycle
- push_addr  in  ADDR_W  store address
- push_ready  out  1  buffer can accept (not full)
- ram_req  out  1  head entry valid, requesting RAM write
- ram_addr  out  ADDR_W  head address
- ram_data  out  DATA_W  head data
- ram_grant  in  1  RAM write performed this cycle
- ld_addr  in  ADDR_W  load lookup address
- ld_hit  out  1  pending store matches ld_addr
- ld_data  out  DATA_W  data of youngest matching entry
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation

- Data select (combinational): fwd_en=1 → fwd_data; else src_sel<NUM_SRC → source src_sel; else NOP_VALUE.
- Push: when push_valid && push_ready at a clock edge, write {push_addr, selected data} at the tail, tail+1 mod DEPTH.
- push_ready = (count != DEPTH). A push while full is ignored, and the buffer state is unchanged. A same-cycle pop does not free space for a push while full.
- Drain: ram_req = (count != 0). ram_addr/ram_data come from the head entry. On an edge with ram_req && ram_grant, head+1 mod DEPTH.
- ram_grant while empty is ignored.
- Simultaneous push and pop (0<count<DEPTH): both occur, and count is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. count is a separate counter, 0..DEPTH.
- Load forwarding: ld_hit=1 if any valid entry has addr==ld_addr. ld_data is the data of the matching entry nearest the tail (youngest). A store pushed in the same cycle is not visible to lookup until the next cycle. An entry popped this cycle is still visible this cycle.
- FIFO order is strict; the RAM sees stores in push order.

## Timing

- Reset (rst=0 at edge): head=tail=count=0, all entries cleared to 0. After reset: push_ready=1, ram_req=0, ram_addr=0, ram_data=0, ld_hit=0, ld_data=0.
- Reset mid-operation discards all pending stores. Reset dominates push and grant in the same cycle.
- Push-to-ram_req latency: 1 cycle (push at edge N, ram_req high after edge N).
- ram_req, ram_addr, ram_data and count change only after clock edges. push_ready depends only on count. ld_hit/ld_data are combinational in ld_addr and state.
- Throughput: one push and one pop per cycle.

## Configuration

- STORE_BUF_LDFWD_EN defined: load-forwarding comparators and youngest-match priority logic are built as described.
- Not defined: no comparators; ld_hit and ld_data are tied to 0, ld_addr is unused, and all other behaviour is identical.

## Test plan

- Reset, then push addr 0x0010 with src_sel=1, src1=0xBEEF, fwd_en=0, ram_grant=0 → next cycle ram_req=1, ram_addr=0x0010, ram_data=0xBEEF, count=1.
- Push with fwd_en=1, fwd_data=0x1234, src_sel=0 → queued data 0x1234. Push with src_sel=4 (NUM_SRC=4), fwd_en=0 → queued data 0x0101.
- 5 pushes with ram_grant=0 → count=4, push_ready=0, and the 5th store is absent. Then grant for 4 cycles → RAM sees addresses in push order, and the pointers wrap on the next fill.
- count=2 with push_valid=1 and ram_grant=1 for 6 cycles → count stays 2, and every pushed store reaches the RAM in order.
- (STORE_BUF_LDFWD_EN) push 0x0020←0x1111, then 0x0020←0x2222, and ld_addr=0x0020 → ld_hit=1, ld_data=0x2222. ld_addr=0x0030 → ld_hit=0. Without the macro, ld_hit=0 always.
- Fill 3 entries, assert rst=0 with push_valid=1 and ram_grant=1 → next cycle count=0, ram_req=0, push_ready=1, ld_hit=0.

Source files
------------

// File: rtl/store_data_buffer_if.sv
// Store-data buffer bus: pipeline-side push/select, RAM drain port and load lookup.
// slave = buffer side, master = pipeline/RAM/testbench side.
interface store_data_buffer_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 4
);
  localparam int SEL_W = $clog2(NUM_SRC) + 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]          src_sel;
  logic                      fwd_en;
  logic [DATA_W-1:0]         fwd_data;
  logic                      push_valid;
  logic [ADDR_W-1:0]         push_addr;
  logic                      push_ready;
  logic                      ram_req;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_data;
  logic                      ram_grant;
  logic [ADDR_W-1:0]         ld_addr;
  logic                      ld_hit;
  logic [DATA_W-1:0]         ld_data;
  logic [CNT_W-1:0]          count;

  modport slave (
    input  src_data, src_sel, fwd_en, fwd_data, push_valid, push_addr, ram_grant, ld_addr,
    output push_ready, ram_req, ram_addr, ram_data, ld_hit, ld_data, count
  );

  modport master (
    output src_data, src_sel, fwd_en, fwd_data, push_valid, push_addr, ram_grant, ld_addr,
    input  push_ready, ram_req, ram_addr, ram_data, ld_hit, ld_data, count
  );
endinterface

// File: rtl/store_data_buffer.sv
// MEM-stage store-data buffer: source/forward select, DEPTH-entry FIFO drained to RAM.
// Define STORE_BUF_LDFWD_EN to build youngest-match load forwarding; otherwise ld_hit/ld_data are 0.
module store_data_buffer #(
  parameter int              DATA_W    = 16,
  parameter int              ADDR_W    = 16,
  parameter int              NUM_SRC   = 4,
  parameter int              DEPTH     = 4,
  parameter logic [15:0]     NOP_VALUE = 16'h0101
) (
  input  logic                 clk,
  input  logic                 rst,
  store_data_buffer_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_SRC) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [DATA_W-1:0] NOP_D = DATA_W'(NOP_VALUE);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [DATA_W-1:0] w_sel_data;
  logic              w_full, w_empty, w_push, w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  // Push eligibility looks only at the current count, so a pop never frees a slot while full.
  assign w_push  = bus.push_valid && !w_full;
  assign w_pop   = bus.ram_grant && !w_empty;

  always_comb begin
    w_sel_data = NOP_D;
    if (bus.fwd_en) begin
      w_sel_data = bus.fwd_data;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus.src_sel == SEL_W'(i)) w_sel_data = bus.src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[r_tail] <= bus.push_addr;
        r_data[r_tail] <= w_sel_data;
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_pop) r_head <= r_head + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  assign bus.push_ready = !w_full;
  assign bus.ram_req    = !w_empty;
  assign bus.ram_addr   = r_addr[r_head];
  assign bus.ram_data   = r_data[r_head];
  assign bus.count      = r_count;

`ifdef STORE_BUF_LDFWD_EN
  logic              w_ld_hit;
  logic [DATA_W-1:0] w_ld_data;

  // Walk oldest to youngest so the last valid match wins.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    v_idx     = '0;
    w_ld_hit  = 1'b0;
    w_ld_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (r_addr[v_idx] == bus.ld_addr)) begin
        w_ld_hit  = 1'b1;
        w_ld_data = r_data[v_idx];
      end
    end
  end

  assign bus.ld_hit  = w_ld_hit;
  assign bus.ld_data = w_ld_data;
`else
  logic w_unused_ld;
  assign w_unused_ld = ^bus.ld_addr;
  assign bus.ld_hit  = 1'b0;
  assign bus.ld_data = '0;
`endif
endmodule

// File: tb/tb_store_data_buffer.sv
// Randomized + directed bench for store_data_buffer against a queue-based reference model.
module tb_store_data_buffer;
  localparam int DATA_W = 16, ADDR_W = 16, NUM_SRC = 4, DEPTH = 4;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  ent_t q[$];
  ent_t e;

  always #5 clk = ~clk;

  store_data_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) bus ();

  store_data_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] sel_data();
    logic [DATA_W-1:0] src [NUM_SRC];
    for (int i = 0; i < NUM_SRC; i++) src[i] = bus.src_data[i*DATA_W +: DATA_W];
    if (bus.fwd_en) return bus.fwd_data;
    if (int'(bus.src_sel) < NUM_SRC) return src[bus.src_sel];
    return 16'h0101;
  endfunction

  task automatic check_model();
    logic              hit;
    logic [DATA_W-1:0] ld;
    hit = 1'b0;
    ld  = '0;
`ifdef STORE_BUF_LDFWD_EN
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == bus.ld_addr) begin
        hit = 1'b1;
        ld  = q[i].d;
        break;
      end
    end
`endif
    chk("push_ready", 32'(bus.push_ready), 32'(q.size() != DEPTH));
    chk("ram_req",    32'(bus.ram_req),    32'(q.size() != 0));
    chk("count",      32'(bus.count),      32'(q.size()));
    chk("ld_hit",     32'(bus.ld_hit),     32'(hit));
    chk("ld_data",    32'(bus.ld_data),    32'(ld));
    if (q.size() != 0) begin
      chk("ram_addr", 32'(bus.ram_addr), 32'(q[0].a));
      chk("ram_data", 32'(bus.ram_data), 32'(q[0].d));
    end
  endtask

  task automatic model_update();
    int sz;
    sz = q.size();
    if (!rst) begin
      q.delete();
    end else begin
      e.a = bus.push_addr;
      e.d = sel_data();
      if (bus.ram_grant && sz != 0) void'(q.pop_front());
      if (bus.push_valid && sz != DEPTH) q.push_back(e);
    end
  endtask

  // Inputs are set on the falling edge; outputs checked 1 time unit later.
  task automatic step();
    #1 check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst            = 1'b1;
    bus.push_valid = 1'b0;
    bus.ram_grant  = 1'b0;
    bus.fwd_en     = 1'b0;
    bus.src_sel    = '0;
  endtask

  task automatic push(input logic [15:0] a, input logic [2:0] sel, input logic fe, input logic [15:0] fd);
    bus.push_valid = 1'b1;
    bus.push_addr  = a;
    bus.src_sel    = sel;
    bus.fwd_en     = fe;
    bus.fwd_data   = fd;
  endtask

  initial begin
    rst            = 1'b0;
    bus.src_data   = {16'hD003, 16'hC002, 16'hBEEF, 16'hA000};
    bus.src_sel    = '0;
    bus.fwd_en     = 1'b0;
    bus.fwd_data   = '0;
    bus.push_valid = 1'b0;
    bus.push_addr  = '0;
    bus.ram_grant  = 1'b0;
    bus.ld_addr    = '0;
    @(posedge clk);
    model_update();
    @(negedge clk);
    idle();

    // Reset state
    #1;
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
    chk("rst_ram_data", 32'(bus.ram_data), 32'h0);
    chk("rst_ready",    32'(bus.push_ready), 32'h1);

    // Single push from src1
    push(16'h0010, 3'd1, 1'b0, 16'h0);
    step();
    idle();
    #1;
    chk("tp1_req",   32'(bus.ram_req),  32'h1);
    chk("tp1_addr",  32'(bus.ram_addr), 32'h0010);
    chk("tp1_data",  32'(bus.ram_data), 32'hBEEF);
    chk("tp1_count", 32'(bus.count),    32'h1);

    // Forwarded data, then NOP source
    push(16'h0011, 3'd0, 1'b1, 16'h1234);
    step();
    push(16'h0012, 3'd4, 1'b0, 16'h0);
    step();
    idle();
    bus.ram_grant = 1'b1;
    step();
    #1 chk("fwd_data", 32'(bus.ram_data), 32'h1234);
    step();
    #1 chk("nop_data", 32'(bus.ram_data), 32'h0101);
    step();
    idle();

    // Overfill: 5th push is dropped
    for (int i = 0; i < 5; i++) begin
      push(16'h0100 + 16'(i), 3'(i % 4), 1'b0, 16'h0);
      step();
    end
    idle();
    #1;
    chk("full_count", 32'(bus.count),      32'h4);
    chk("full_ready", 32'(bus.push_ready), 32'h0);
    // Push+grant while full: push still refused
    push(16'h0DEF, 3'd2, 1'b0, 16'h0);
    bus.ram_grant = 1'b1;
    step();
    bus.push_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    idle();
    #1 chk("drained", 32'(bus.count), 32'h0);
    for (int i = 0; i < 4; i++) begin
      push(16'h0200 + 16'(i), 3'd3, 1'b0, 16'h0);
      step();
    end
    idle();
    bus.ram_grant = 1'b1;
    for (int i = 0; i < 4; i++) step();
    idle();

    // Steady state: count 2 with push and pop every cycle
    push(16'h0300, 3'd0, 1'b0, 16'h0); step();
    push(16'h0301, 3'd1, 1'b0, 16'h0); step();
    bus.ram_grant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(16'h0302 + 16'(i), 3'(i % 4), 1'b1, 16'h5000 + 16'(i));
      step();
      #1 chk("steady_count", 32'(bus.count), 32'h2);
    end
    idle();
    bus.ram_grant = 1'b1;
    step(); step();
    idle();

    // Load forwarding youngest match
    push(16'h0020, 3'd0, 1'b1, 16'h1111); step();
    push(16'h0020, 3'd0, 1'b1, 16'h2222); step();
    idle();
    bus.ld_addr = 16'h0020;
    #1;
`ifdef STORE_BUF_LDFWD_EN
    chk("ld_young_hit",  32'(bus.ld_hit),  32'h1);
    chk("ld_young_data", 32'(bus.ld_data), 32'h2222);
`else
    chk("ld_off_hit",    32'(bus.ld_hit),  32'h0);
`endif
    bus.ld_addr = 16'h0030;
    #1 chk("ld_miss", 32'(bus.ld_hit), 32'h0);
    step();

    // Reset dominates push and grant
    push(16'h0040, 3'd1, 1'b0, 16'h0);
    step();
    rst = 1'b0;
    bus.ram_grant = 1'b1;
    bus.ld_addr   = 16'h0040;
    step();
    idle();
    bus.ld_addr = 16'h0040;
    #1;
    chk("rst_count", 32'(bus.count),      32'h0);
    chk("rst_req",   32'(bus.ram_req),    32'h0);
    chk("rst_rdy",   32'(bus.push_ready), 32'h1);
    chk("rst_hit",   32'(bus.ld_hit),     32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst            = ($urandom_range(63) != 0);
      bus.push_valid = ($urandom_range(3) != 0);
      bus.ram_grant  = ($urandom_range(2) != 0);
      bus.push_addr  = 16'h0020 + 16'($urandom_range(3));
      bus.ld_addr    = 16'h0020 + 16'($urandom_range(4));
      bus.src_sel    = 3'($urandom_range(7));
      bus.fwd_en     = ($urandom_range(3) == 0);
      bus.fwd_data   = 16'($urandom);
      bus.src_data   = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
